// File: rtl/sdp_core_split_if.sv
// Handshake bundle for the SDP wide-to-narrow splitter: one wide input word
// channel and one narrow output beat channel, both valid/ready.
interface sdp_core_split_if #(
  parameter int IW = 512,
  parameter int OW = 128
);
  logic          inp_pvld;
  logic          inp_prdy;
  logic [IW-1:0] inp_data;
  logic [3:0]    inp_nbeat;
  logic          out_pvld;
  logic          out_prdy;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [3:0]    out_beat;

  // master: the environment around the splitter (word producer + beat consumer)
  modport master (
    output inp_pvld, inp_data, inp_nbeat, out_prdy,
    input  inp_prdy, out_pvld, out_data, out_last, out_beat
  );

  // slave: the splitter itself
  modport slave (
    input  inp_pvld, inp_data, inp_nbeat, out_prdy,
    output inp_prdy, out_pvld, out_data, out_last, out_beat
  );
endinterface

// File: rtl/sdp_core_split.sv
// Width-down converter: holds one IW-bit word and streams it out as up to
// RATIO OW-bit beats, LSB segment first, with zero-bubble word handoff.
module sdp_core_split #(
  parameter int IW    = 512,
  parameter int OW    = 128,
  parameter int RATIO = IW / OW
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  sdp_core_split_if.slave  bus
);

  localparam logic [3:0] NBEAT_MAX = 4'(RATIO - 1);

  if (!((RATIO == 1) || (RATIO == 2) || (RATIO == 4) || (RATIO == 8) || (RATIO == 16))
      || (RATIO * OW != IW)) begin : g_bad_ratio
    $error("sdp_core_split: RATIO must be 1, 2, 4, 8 or 16 with IW == RATIO*OW");
  end

  logic          hold_q, hold_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    nbeat_q, nbeat_d;
  logic [IW-1:0] data_q, data_d;

  logic          out_last_s;
  logic          inp_prdy_s;
  logic          inp_acc_s;
  logic          out_acc_s;
  logic [3:0]    nbeat_clamp_s;
  logic [OW-1:0] seg_s;

  // Handshake qualifiers; a last-beat transfer frees the holder in the same cycle
  always_comb begin
    out_last_s    = hold_q & (cnt_q == nbeat_q);
    inp_prdy_s    = ~hold_q | (bus.out_prdy & out_last_s);
    inp_acc_s     = bus.inp_pvld & inp_prdy_s;
    out_acc_s     = hold_q & bus.out_prdy;
    nbeat_clamp_s = (bus.inp_nbeat > NBEAT_MAX) ? NBEAT_MAX : bus.inp_nbeat;
  end

  // Beat selector: segment cnt_q of the held word
  always_comb begin
    seg_s = data_q[OW-1:0];
    for (int k = 0; k < RATIO; k++) begin
      seg_s = (cnt_q == 4'(k)) ? data_q[k*OW +: OW] : seg_s;
    end
  end

  // Next-state: a new word load wins over the beat advance of the same cycle
  always_comb begin
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    nbeat_d = nbeat_q;
    data_d  = data_q;
    if (inp_acc_s) begin
      hold_d  = 1'b1;
      cnt_d   = 4'd0;
      nbeat_d = nbeat_clamp_s;
      data_d  = bus.inp_data;
    end else if (out_acc_s) begin
      if (out_last_s) begin
        hold_d = 1'b0;
        cnt_d  = 4'd0;
      end else begin
        cnt_d  = cnt_q + 4'd1;
      end
    end else begin
      hold_d = hold_q;
    end
  end

  // Control state register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      hold_q  <= 1'b0;
      cnt_q   <= 4'd0;
      nbeat_q <= 4'd0;
    end else begin
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      nbeat_q <= nbeat_d;
    end
  end

  // Word payload; content is meaningless while the holder is empty, so no reset
  always_ff @(posedge nvdla_core_clk) begin
    data_q <= data_d;
  end

  assign bus.out_pvld = hold_q;
  assign bus.out_data = seg_s;
  assign bus.out_beat = cnt_q;
  assign bus.out_last = out_last_s;
  assign bus.inp_prdy = inp_prdy_s;

endmodule

// File: tb/tb_sdp_core_split.sv
// Scoreboard bench for sdp_core_split: RATIO=4 main instance plus a sweep of
// RATIO 1/2/8/16 instances checked for segment order and gap-free timing.
module tb_sdp_core_split;

  localparam int OW = 128;
  localparam int IW = 512;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [3:0]    beat;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_sw_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic bp_on = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sdp_core_split_if #(.IW(IW), .OW(OW)) m_if ();

  sdp_core_split #(.IW(IW), .OW(OW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .bus             (m_if)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [OW-1:0] segv(input logic [7:0] tag, input logic [7:0] w, input logic [3:0] k);
    return {tag, w, 4'h0, k, {13{8'h5A}}};
  endfunction

  // ---------------- main instance scoreboard ----------------
  exp_t mq[$];
  int   m_xfer = 0;
  int   m_last_cyc = 0;

  initial begin : m_mon
    exp_t          e;
    logic          st_prev;
    logic [OW-1:0] st_data;
    logic [4:0]    st_bl;
    st_prev = 1'b0;
    st_data = '0;
    st_bl   = 5'd0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (m_if.out_pvld && !(m_if.out_prdy && m_if.out_last))
          chk("inp_prdy_while_pending", 128'(m_if.inp_prdy), 128'd0);
        if (st_prev && m_if.out_pvld) begin
          chk("stall_data_stable", 128'(m_if.out_data), 128'(st_data));
          chk("stall_beat_last_stable", 128'({m_if.out_beat, m_if.out_last}), 128'(st_bl));
        end
        if (m_if.out_pvld && m_if.out_prdy) begin
          m_xfer++;
          m_last_cyc = cyc;
          if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat %0d with empty queue", m_if.out_beat);
          end else begin
            e = mq.pop_front();
            chk("beat_data", 128'(m_if.out_data), 128'(e.data));
            chk("beat_idx_last", 128'({m_if.out_beat, m_if.out_last}), 128'({e.beat, e.last}));
          end
        end
        st_prev = m_if.out_pvld && !m_if.out_prdy;
        st_data = m_if.out_data;
        st_bl   = {m_if.out_beat, m_if.out_last};
      end else begin
        st_prev = 1'b0;
      end
    end
  end

  initial begin : bp_gen
    forever begin
      @(posedge clk);
      #1;
      m_if.out_prdy = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_word(input logic [IW-1:0] d, input logic [3:0] nb);
    bit acc;
    acc = 1'b0;
    m_if.inp_pvld  = 1'b1;
    m_if.inp_data  = d;
    m_if.inp_nbeat = nb;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = m_if.inp_prdy;
      @(posedge clk);
      #1;
    end
    if (!acc) timeout_fail("input_accept");
    m_if.inp_pvld = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input logic [3:0] nb);
    logic [IW-1:0] d;
    logic [3:0]    c;
    exp_t          e;
    c = (nb > 4'd3) ? 4'd3 : nb;
    for (int k = 0; k < 4; k++) d[k*OW +: OW] = segv(8'hC0, w, 4'(k));
    for (int k = 0; k <= int'(c); k++) begin
      e.data = segv(8'hC0, w, 4'(k));
      e.beat = 4'(k);
      e.last = (k == int'(c));
      mq.push_back(e);
    end
    drive_word(d, nb);
  endtask

  task automatic drain(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = (mq.size() == 0) && !m_if.out_pvld;
    end
    if (!ok) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  // ---------------- RATIO sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int SR  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    localparam int SIW = SR * OW;

    sdp_core_split_if #(.IW(SIW), .OW(OW)) s_if ();

    sdp_core_split #(.IW(SIW), .OW(OW)) s_dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rst_sw_n),
      .bus             (s_if)
    );

    exp_t q[$];
    int   xfer = 0;
    int   last_cyc = 0;
    logic done = 1'b0;

    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst_sw_n === 1'b1 && s_if.out_pvld && s_if.out_prdy) begin
          xfer++;
          last_cyc = cyc;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL r%0d_unexpected_beat: got beat %0d with empty queue", SR, s_if.out_beat);
          end else begin
            e = q.pop_front();
            chk($sformatf("r%0d_beat_data", SR), 128'(s_if.out_data), 128'(e.data));
            chk($sformatf("r%0d_beat_idx_last", SR), 128'({s_if.out_beat, s_if.out_last}),
                128'({e.beat, e.last}));
          end
        end
      end
    end

    initial begin : drv
      logic [SIW-1:0] d;
      logic [3:0]     nb;
      exp_t           e;
      int             nbeats, x0, c0;
      bit             acc, ok;
      s_if.inp_pvld  = 1'b0;
      s_if.inp_data  = '0;
      s_if.inp_nbeat = 4'd0;
      s_if.out_prdy  = 1'b1;
      wait (rst_sw_n === 1'b1);
      @(posedge clk);
      #1;
      x0 = xfer;
      c0 = cyc;
      // full word, over-range nbeat (clamped to full), then a single-beat word
      for (int w = 0; w < 3; w++) begin
        nb     = (w == 0) ? 4'(SR - 1) : (w == 1) ? 4'd15 : 4'd0;
        nbeats = (w == 2) ? 1 : SR;
        for (int k = 0; k < SR; k++) d[k*OW +: OW] = segv(8'(SR), 8'(w), 4'(k));
        for (int k = 0; k < nbeats; k++) begin
          e.data = segv(8'(SR), 8'(w), 4'(k));
          e.beat = 4'(k);
          e.last = (k == nbeats - 1);
          q.push_back(e);
        end
        s_if.inp_pvld  = 1'b1;
        s_if.inp_data  = d;
        s_if.inp_nbeat = nb;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
          @(negedge clk);
          acc = s_if.inp_prdy;
          @(posedge clk);
          #1;
        end
        if (!acc) timeout_fail($sformatf("r%0d_accept", SR));
        s_if.inp_pvld = 1'b0;
      end
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        ok = (q.size() == 0) && !s_if.out_pvld;
      end
      if (!ok) timeout_fail($sformatf("r%0d_drain", SR));
      chk($sformatf("r%0d_beat_count", SR), 128'(xfer - x0), 128'(2 * SR + 1));
      chk($sformatf("r%0d_gapfree_cycles", SR), 128'(last_cyc - c0), 128'(2 * SR + 1));
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int x0, c0;
    bit ok;
    rst_n          = 1'b0;
    rst_sw_n       = 1'b0;
    m_if.inp_pvld  = 1'b0;
    m_if.inp_data  = '0;
    m_if.inp_nbeat = 4'd0;
    m_if.out_prdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_pvld", 128'(m_if.out_pvld), 128'd0);
    chk("reset_out_last", 128'(m_if.out_last), 128'd0);
    chk("reset_out_beat", 128'(m_if.out_beat), 128'd0);
    chk("reset_inp_prdy", 128'(m_if.inp_prdy), 128'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;
    @(posedge clk);
    #1;

    // single full word: beats on cycles c0+1..c0+4
    x0 = m_xfer;
    c0 = cyc;
    send(8'h01, 4'd3);
    drain(50);
    chk("single_beat_count", 128'(m_xfer - x0), 128'd4);
    chk("single_latency", 128'(m_last_cyc - c0), 128'd4);

    // 8 back-to-back words: 32 contiguous beats
    x0 = m_xfer;
    c0 = cyc;
    for (int w = 0; w < 8; w++) send(8'(8'h10 + w), 4'd3);
    drain(100);
    chk("stream_beat_count", 128'(m_xfer - x0), 128'd32);
    chk("stream_gapfree", 128'(m_last_cyc - c0), 128'd32);

    // short word, clamp, single beat: 2 + 4 + 1 beats
    x0 = m_xfer;
    send(8'h20, 4'd1);
    send(8'h21, 4'd9);
    send(8'h22, 4'd0);
    drain(100);
    chk("short_clamp_beat_count", 128'(m_xfer - x0), 128'd7);

    // random output backpressure: 4+2+3+1+4+4 beats
    bp_on = 1'b1;
    x0 = m_xfer;
    send(8'h30, 4'd3);
    send(8'h31, 4'd1);
    send(8'h32, 4'd2);
    send(8'h33, 4'd0);
    send(8'h34, 4'd3);
    send(8'h35, 4'd12);
    drain(600);
    bp_on = 1'b0;
    chk("backpressure_beat_count", 128'(m_xfer - x0), 128'd18);
    @(posedge clk);
    #1;

    // reset after beat 1 of a 4-beat word
    x0 = m_xfer;
    send(8'h50, 4'd3);
    for (int i = 0; i < 20 && (m_xfer - x0) < 2; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_out_pvld", 128'(m_if.out_pvld), 128'd0);
    chk("midreset_inp_prdy", 128'(m_if.inp_prdy), 128'd1);
    chk("midreset_out_beat", 128'(m_if.out_beat), 128'd0);
    chk("midreset_beats_before", 128'(m_xfer - x0), 128'd2);
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h51, 4'd3);
    drain(50);
    chk("postreset_beat_count", 128'(m_xfer - x0), 128'd6);

    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done;
    end
    if (!ok) timeout_fail("sweep_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
